nexys_starship_monster_ctrl: RTL and testbench
==============================================

// Module: nexys_starship_monster_ctrl
// PURPOSE
//  Consumes the per-side spawn strobes and random_hex from the starship PRNG and runs the monster lifecycle.
//  For each of four sides (0=top,1=btm,2=left,3=right) it decides spawn -> alive/countdown -> killed or expired.
//  Drives display/score logic downstream and raises game_over when any monster outlives its timeout.
// PARAMETERS
//  TICK_DIV       50_000_000  Clk cycles per game tick (internal divider)
//  TIMEOUT_TICKS  10          ticks a monster lives before game over (>=1)
//  MIN_GAP_TICKS  2           per-side cooldown ticks after a kill before respawn allowed (0 = none)
//  SCORE_W        8           score width
// PORTS
//  Clk             in   1        system clock, all logic posedge
//  Reset_n         in   1        asynchronous, active-low reset
//  game_en         in   1        level; 1 = game running
//  top_random      in   1        PRNG spawn request, side 0
//  btm_random      in   1        PRNG spawn request, side 1
//  left_random     in   1        PRNG spawn request, side 2
//  right_random    in   1        PRNG spawn request, side 3
//  random_hex      in   4        PRNG code, latched as monster code at spawn
//  shoot_valid     in   1        1-cycle shot strobe
//  shoot_dir       in   2        side targeted by shot
//  shoot_hex       in   4        code entered by player
//  monster_active  out  4        bit i = side i monster alive
//  monster_hex     out  16       [4i+3:4i] = code of side i (0 when side idle)
//  score           out  SCORE_W  kills, saturating at all-ones
//  game_over       out  1        sticky expiry flag
//  hit_pulse       out  1        1-cycle, valid shot killed a monster
//  miss_pulse      out  1        1-cycle, valid shot killed nothing
// BEHAVIOUR
//  - Reset_n low: all outputs, timers, cooldowns, divider, FSMs = 0 immediately; abandons mid-game state.
//  - Divider: counts 0..TICK_DIV-1 while game_en & !game_over; tick = 1 cycle at wrap; held at 0 otherwise.
//  - Per-side FSM, states IDLE/ALIVE; all transitions registered (1-cycle latency input->output).
//  - IDLE->ALIVE: game_en & !game_over & side_random & cooldown==0; timer<=TIMEOUT_TICKS, code<=random_hex same cycle.
//  - Sides independent; up to four spawns in one cycle, all share that cycle's random_hex.
//  - side_random while ALIVE: ignored (no restart, no code change).
//  - ALIVE: timer decrements on tick; tick with timer==1 -> expiry: game_over<=1, side stays ALIVE.
//  - Shot (shoot_valid & game_en & !game_over): hit iff side shoot_dir ALIVE & shoot_hex==code.
//    hit -> side IDLE, code<=0, cooldown<=MIN_GAP_TICKS, score+1 (saturate), hit_pulse next cycle.
//    else -> miss_pulse next cycle, no other effect. Shots while !game_en or game_over: no pulses.
//  - Cooldown decrements on tick, floors at 0; spawn blocked while nonzero.
//  - Hit and expiry on same side same cycle: hit wins, no game_over.
//  - Expiry on one side + hit on another: both take effect.
//  - Spawn and shot at an IDLE side same cycle: shot is a miss; spawn proceeds.
//  - game_over: freezes timers, cooldowns, spawns, divider; monster_active/monster_hex/score hold.
//  - game_en low (sync): all sides IDLE, codes/timers/cooldowns/divider/game_over cleared; score holds.
//  - game_en 0->1 (registered edge detect): score cleared same cycle divider starts.
// TESTING  (TICK_DIV=4, TIMEOUT_TICKS=3, MIN_GAP_TICKS=2)
//  1 Reset_n low mid-game with monster_active=4'b0101, score=5 -> all outputs 0 asynchronously, before next edge.
//  2 game_en=1, top_random=1 one cycle, random_hex=4'hA -> next cycle monster_active=4'b0001, monster_hex[3:0]=A.
//  3 Then shoot_dir=0, shoot_hex=A -> hit_pulse 1 cycle, active=0, score=1.
//    top_random held 1 -> respawn exactly 2 ticks (8 cycles) later.
//  4 Left spawn, no shots -> game_over=1 at 3rd tick (12 cycles); later right_random and shots ignored, no pulses.
//  5 Shot dir=1, hex=3 at idle btm -> miss_pulse only.
//    Shot dir=2 with wrong hex at alive left -> miss_pulse, left stays alive.
//  6 Hit on top in the expiry cycle of top -> hit_pulse, score+1, game_over=0.
//    score=8'hFF + hit -> score stays FF.

Source files
------------

// File: rtl/nexys_starship_monster_ctrl.sv
// Monster lifecycle for the four screen sides: spawn, countdown, kill or expiry.
// Tracks score, sticky game_over and one-cycle hit/miss feedback pulses.
module nexys_starship_monster_ctrl #(
   parameter int TICK_DIV      = 50_000_000,
   parameter int TIMEOUT_TICKS = 10,
   parameter int MIN_GAP_TICKS = 2,
   parameter int SCORE_W       = 8
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               game_en,
   input  logic               top_random,
   input  logic               btm_random,
   input  logic               left_random,
   input  logic               right_random,
   input  logic [3:0]         random_hex,
   input  logic               shoot_valid,
   input  logic [1:0]         shoot_dir,
   input  logic [3:0]         shoot_hex,
   output logic [3:0]         monster_active,
   output logic [15:0]        monster_hex,
   output logic [SCORE_W-1:0] score,
   output logic               game_over,
   output logic               hit_pulse,
   output logic               miss_pulse
);

   localparam int DW = $clog2(TICK_DIV + 1);
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   localparam int CW = $clog2(MIN_GAP_TICKS + 2);
   localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
   localparam logic [TW-1:0] TMO     = TW'(TIMEOUT_TICKS);
   localparam logic [CW-1:0] GAP     = CW'(MIN_GAP_TICKS);

   typedef enum logic {IDLE, ALIVE} side_st_e;

   side_st_e           st_q   [4];
   side_st_e           st_d   [4];
   logic [TW-1:0]      tmr_q  [4];
   logic [TW-1:0]      tmr_d  [4];
   logic [CW-1:0]      cd_q   [4];
   logic [CW-1:0]      cd_d   [4];
   logic [3:0]         code_q [4];
   logic [3:0]         code_d [4];
   logic [DW-1:0]      div_q, div_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               over_q, over_d;
   logic               hit_q, hit_d;
   logic               miss_q, miss_d;
   logic               en_q;
   logic               run, tick, shot, hit;
   logic [3:0]         req;

   assign req  = {right_random, left_random, btm_random, top_random};
   assign run  = game_en & ~over_q;
   assign tick = run & (div_q == DIV_MAX);
   assign shot = shoot_valid & run;
   assign hit  = shot & (st_q[shoot_dir] == ALIVE)
               & (shoot_hex == code_q[shoot_dir]);

   always_comb begin
      div_d   = '0;
      over_d  = over_q;
      score_d = score_q;
      hit_d   = hit;
      miss_d  = shot & ~hit;
      for (int i = 0; i < 4; i++) begin
         st_d[i]   = st_q[i];
         tmr_d[i]  = tmr_q[i];
         cd_d[i]   = cd_q[i];
         code_d[i] = code_q[i];
      end
      if (run && !tick) div_d = div_q + 1'b1;
      if (!game_en) begin
         over_d = 1'b0;
         for (int i = 0; i < 4; i++) begin
            st_d[i]   = IDLE;
            tmr_d[i]  = '0;
            cd_d[i]   = '0;
            code_d[i] = '0;
         end
      end else if (!over_q) begin
         if (!en_q) score_d = '0;
         else if (hit && score_q != '1) score_d = score_q + 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (tick && cd_q[i] != '0) cd_d[i] = cd_q[i] - 1'b1;
            if (st_q[i] == IDLE) begin
               if (req[i] && cd_q[i] == '0) begin
                  st_d[i]   = ALIVE;
                  tmr_d[i]  = TMO;
                  code_d[i] = random_hex;
               end
            end else if (hit && shoot_dir == 2'(i)) begin
               // a kill in the expiry cycle saves the game
               st_d[i]   = IDLE;
               tmr_d[i]  = '0;
               cd_d[i]   = GAP;
               code_d[i] = '0;
            end else if (tick) begin
               tmr_d[i] = tmr_q[i] - 1'b1;
               if (tmr_q[i] == TW'(1)) over_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         div_q   <= '0;
         score_q <= '0;
         over_q  <= 1'b0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
         en_q    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            st_q[i]   <= IDLE;
            tmr_q[i]  <= '0;
            cd_q[i]   <= '0;
            code_q[i] <= '0;
         end
      end else begin
         div_q   <= div_d;
         score_q <= score_d;
         over_q  <= over_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         en_q    <= game_en;
         for (int i = 0; i < 4; i++) begin
            st_q[i]   <= st_d[i];
            tmr_q[i]  <= tmr_d[i];
            cd_q[i]   <= cd_d[i];
            code_q[i] <= code_d[i];
         end
      end
   end

   always_comb begin
      monster_active = '0;
      monster_hex    = '0;
      for (int i = 0; i < 4; i++) begin
         monster_active[i]    = (st_q[i] == ALIVE);
         monster_hex[4*i +: 4] = code_q[i];
      end
   end

   assign score      = score_q;
   assign game_over  = over_q;
   assign hit_pulse  = hit_q;
   assign miss_pulse = miss_q;

endmodule

// File: tb/tb_nexys_starship_monster_ctrl.sv
// Bench for the monster controller with a 4-cycle tick, 3-tick timeout, 2-tick gap.
// Shot outcomes are queued when driven and checked on the following cycle.
module tb_nexys_starship_monster_ctrl;

   localparam logic [1:0] HIT  = 2'b10;
   localparam logic [1:0] MISS = 2'b01;
   localparam logic [1:0] NONE = 2'b00;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        game_en = 1'b0;
   logic        top_random = 1'b0;
   logic        btm_random = 1'b0;
   logic        left_random = 1'b0;
   logic        right_random = 1'b0;
   logic [3:0]  random_hex = '0;
   logic        shoot_valid = 1'b0;
   logic [1:0]  shoot_dir = '0;
   logic [3:0]  shoot_hex = '0;
   logic [3:0]  monster_active;
   logic [15:0] monster_hex;
   logic [7:0]  score;
   logic        game_over;
   logic        hit_pulse;
   logic        miss_pulse;

   int          n_run = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [1:0]  sb [$];
   logic [1:0]  exp_p;

   nexys_starship_monster_ctrl #(
      .TICK_DIV(4), .TIMEOUT_TICKS(3), .MIN_GAP_TICKS(2), .SCORE_W(8)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .game_en(game_en),
      .top_random(top_random), .btm_random(btm_random),
      .left_random(left_random), .right_random(right_random),
      .random_hex(random_hex), .shoot_valid(shoot_valid),
      .shoot_dir(shoot_dir), .shoot_hex(shoot_hex),
      .monster_active(monster_active), .monster_hex(monster_hex),
      .score(score), .game_over(game_over),
      .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
      cyc++;
   endtask

   task automatic clear_req();
      top_random = 0; btm_random = 0; left_random = 0; right_random = 0;
   endtask

   task automatic do_reset();
      clear_req();
      shoot_valid = 0;
      game_en = 0;
      Reset_n = 0;
      #12;
      Reset_n = 1;
      step();
   endtask

   // the edge that first samples game_en=1 is cycle 0; ticks land on 3,7,11,...
   task automatic start();
      game_en = 1;
      step();
      cyc = 0;
   endtask

   task automatic shoot(input logic [1:0] d, input logic [3:0] h,
                        input logic [1:0] e);
      shoot_valid = 1; shoot_dir = d; shoot_hex = h;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      do_reset(); start();
      random_hex = 4'h5;
      top_random = 1; btm_random = 1; left_random = 1; right_random = 1;
      step(); clear_req();
      n_run++; if (monster_active !== 4'hF) begin n_fail++;
         $display("FAIL rst_spawn4: got %b want 1111", monster_active); end
      for (int d = 0; d < 4; d++) begin
         shoot(2'(d), 4'h5, HIT); step(); shoot_valid = 0;
         exp_p = sb.pop_front();
         n_run++; if ({hit_pulse, miss_pulse} !== exp_p) begin n_fail++;
            $display("FAIL rst_kill%0d: got %b want %b", d, {hit_pulse, miss_pulse}, exp_p); end
      end
      repeat (10) step();
      random_hex = 4'h6; top_random = 1; btm_random = 1; left_random = 1;
      step(); clear_req();
      shoot(1, 4'h6, HIT); step(); shoot_valid = 0;
      exp_p = sb.pop_front();
      n_run++; if ({hit_pulse, miss_pulse} !== exp_p) begin n_fail++;
         $display("FAIL rst_kill5: got %b want %b", {hit_pulse, miss_pulse}, exp_p); end
      n_run++; if (monster_active !== 4'b0101 || score !== 8'd5) begin n_fail++;
         $display("FAIL rst_pre: active %b score %0d want 0101 5", monster_active, score); end
      Reset_n = 0;
      #1;
      n_run++; if (monster_active !== 4'b0 || monster_hex !== 16'h0) begin n_fail++;
         $display("FAIL rst_async_mon: active %b hex %h want 0 0", monster_active, monster_hex); end
      n_run++; if (score !== 8'd0 || game_over !== 1'b0) begin n_fail++;
         $display("FAIL rst_async_score: score %0d over %b want 0 0", score, game_over); end
      n_run++; if ({hit_pulse, miss_pulse} !== 2'b00) begin n_fail++;
         $display("FAIL rst_async_pulse: got %b want 00", {hit_pulse, miss_pulse}); end
   endtask

   task automatic test_spawn_hit();
      do_reset(); start(); step(); step();
      top_random = 1; random_hex = 4'hA;
      step();
      n_run++; if (monster_active !== 4'b0001 || monster_hex !== 16'h000A) begin n_fail++;
         $display("FAIL spawn_top: active %b hex %h want 0001 000a", monster_active, monster_hex); end
      random_hex = 4'h5;
      shoot(0, 4'hA, HIT); step(); shoot_valid = 0;
      exp_p = sb.pop_front();
      n_run++; if ({hit_pulse, miss_pulse} !== exp_p) begin n_fail++;
         $display("FAIL hit_top: got %b want %b", {hit_pulse, miss_pulse}, exp_p); end
      n_run++; if (monster_active !== 4'b0 || score !== 8'd1) begin n_fail++;
         $display("FAIL hit_state: active %b score %0d want 0000 1", monster_active, score); end
      step();
      n_run++; if ({hit_pulse, miss_pulse} !== 2'b00) begin n_fail++;
         $display("FAIL hit_one_cycle: got %b want 00", {hit_pulse, miss_pulse}); end
      while (cyc < 11) begin
         step();
         n_run++; if (monster_active !== 4'b0) begin n_fail++;
            $display("FAIL cooldown_c%0d: active %b want 0000", cyc, monster_active); end
      end
      step();
      n_run++; if (monster_active !== 4'b0001 || monster_hex !== 16'h0005) begin n_fail++;
         $display("FAIL respawn: active %b hex %h want 0001 0005", monster_active, monster_hex); end
      clear_req();
   endtask

   task automatic test_expiry();
      do_reset(); start(); step(); step();
      left_random = 1; random_hex = 4'hC;
      step(); clear_req();
      while (cyc < 14) step();
      n_run++; if (game_over !== 1'b0) begin n_fail++;
         $display("FAIL expiry_early: got %b want 0", game_over); end
      step();
      n_run++; if (game_over !== 1'b1) begin n_fail++;
         $display("FAIL expiry: got %b want 1", game_over); end
      n_run++; if (monster_active !== 4'b0100 || monster_hex !== 16'h0C00) begin n_fail++;
         $display("FAIL expiry_hold: active %b hex %h want 0100 0c00", monster_active, monster_hex); end
      right_random = 1;
      shoot(2, 4'hC, NONE); step(); shoot_valid = 0; clear_req();
      exp_p = sb.pop_front();
      n_run++; if ({hit_pulse, miss_pulse} !== exp_p) begin n_fail++;
         $display("FAIL over_shot: got %b want %b", {hit_pulse, miss_pulse}, exp_p); end
      repeat (8) step();
      n_run++; if (monster_active !== 4'b0100 || score !== 8'd0 || game_over !== 1'b1) begin
         n_fail++;
         $display("FAIL over_freeze: active %b score %0d over %b want 0100 0 1",
                  monster_active, score, game_over); end
      game_en = 0; step();
      n_run++; if (game_over !== 1'b0 || monster_active !== 4'b0) begin n_fail++;
         $display("FAIL en_clear_over: over %b active %b want 0 0000", game_over, monster_active); end
   endtask

   task automatic test_miss();
      do_reset(); start();
      left_random = 1; random_hex = 4'h9;
      step(); clear_req();
      shoot(1, 4'h3, MISS); step(); shoot_valid = 0;
      exp_p = sb.pop_front();
      n_run++; if ({hit_pulse, miss_pulse} !== exp_p) begin n_fail++;
         $display("FAIL miss_idle: got %b want %b", {hit_pulse, miss_pulse}, exp_p); end
      shoot(2, 4'h8, MISS); step(); shoot_valid = 0;
      exp_p = sb.pop_front();
      n_run++; if ({hit_pulse, miss_pulse} !== exp_p) begin n_fail++;
         $display("FAIL miss_wrong: got %b want %b", {hit_pulse, miss_pulse}, exp_p); end
      n_run++; if (monster_active !== 4'b0100) begin n_fail++;
         $display("FAIL miss_alive: got %b want 0100", monster_active); end
      btm_random = 1; random_hex = 4'h3;
      shoot(1, 4'h3, MISS); step(); shoot_valid = 0; clear_req();
      exp_p = sb.pop_front();
      n_run++; if ({hit_pulse, miss_pulse} !== exp_p) begin n_fail++;
         $display("FAIL spawn_shot: got %b want %b", {hit_pulse, miss_pulse}, exp_p); end
      n_run++; if (monster_active !== 4'b0110 || monster_hex !== 16'h0930 || score !== 8'd0) begin
         n_fail++;
         $display("FAIL spawn_shot_st: active %b hex %h score %0d want 0110 0930 0",
                  monster_active, monster_hex, score); end
   endtask

   task automatic test_hit_expiry();
      do_reset(); start(); step(); step();
      top_random = 1; random_hex = 4'hB;
      step(); clear_req();
      while (cyc < 14) step();
      shoot(0, 4'hB, HIT); step(); shoot_valid = 0;
      exp_p = sb.pop_front();
      n_run++; if ({hit_pulse, miss_pulse} !== exp_p) begin n_fail++;
         $display("FAIL save_pulse: got %b want %b", {hit_pulse, miss_pulse}, exp_p); end
      n_run++; if (score !== 8'd1 || game_over !== 1'b0 || monster_active !== 4'b0) begin
         n_fail++;
         $display("FAIL save_state: score %0d over %b active %b want 1 0 0000",
                  score, game_over, monster_active); end
      do_reset(); start(); step(); step();
      top_random = 1; left_random = 1; random_hex = 4'hB;
      step(); clear_req();
      while (cyc < 14) step();
      shoot(0, 4'hB, HIT); step(); shoot_valid = 0;
      exp_p = sb.pop_front();
      n_run++; if ({hit_pulse, miss_pulse} !== exp_p) begin n_fail++;
         $display("FAIL other_pulse: got %b want %b", {hit_pulse, miss_pulse}, exp_p); end
      n_run++; if (score !== 8'd1 || game_over !== 1'b1 || monster_active !== 4'b0100) begin
         n_fail++;
         $display("FAIL other_state: score %0d over %b active %b want 1 1 0100",
                  score, game_over, monster_active); end
   endtask

   task automatic test_game_en();
      do_reset(); start();
      right_random = 1; random_hex = 4'h7;
      step(); clear_req();
      shoot(3, 4'h7, HIT); step(); shoot_valid = 0;
      exp_p = sb.pop_front();
      n_run++; if ({hit_pulse, miss_pulse} !== exp_p) begin n_fail++;
         $display("FAIL en_hit: got %b want %b", {hit_pulse, miss_pulse}, exp_p); end
      btm_random = 1; random_hex = 4'h2;
      step(); clear_req();
      n_run++; if (monster_active !== 4'b0010) begin n_fail++;
         $display("FAIL en_spawn: got %b want 0010", monster_active); end
      game_en = 0;
      shoot(1, 4'h2, NONE); step(); shoot_valid = 0;
      exp_p = sb.pop_front();
      n_run++; if ({hit_pulse, miss_pulse} !== exp_p) begin n_fail++;
         $display("FAIL en_off_shot: got %b want %b", {hit_pulse, miss_pulse}, exp_p); end
      n_run++; if (monster_active !== 4'b0 || monster_hex !== 16'h0 || score !== 8'd1) begin
         n_fail++;
         $display("FAIL en_off: active %b hex %h score %0d want 0 0 1",
                  monster_active, monster_hex, score); end
      game_en = 1; step();
      n_run++; if (score !== 8'd0) begin n_fail++;
         $display("FAIL en_restart: score %0d want 0", score); end
   endtask

   task automatic test_saturate();
      int exp_score;
      exp_score = 0;
      do_reset(); start();
      for (int r = 0; r < 64; r++) begin
         random_hex = 4'(r);
         top_random = 1; btm_random = 1; left_random = 1; right_random = 1;
         step(); clear_req();
         for (int d = 0; d < 4; d++) begin
            shoot(2'(d), 4'(r), HIT); step(); shoot_valid = 0;
            exp_p = sb.pop_front();
            if (exp_score < 255) exp_score++;
            n_run++; if ({hit_pulse, miss_pulse} !== exp_p || score !== 8'(exp_score)) begin
               n_fail++;
               $display("FAIL sat_r%0d_d%0d: pulse %b score %0d want %b %0d",
                        r, d, {hit_pulse, miss_pulse}, score, exp_p, exp_score); end
         end
         repeat (9) step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_spawn_hit();
      test_expiry();
      test_miss();
      test_hit_expiry();
      test_game_en();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
